// File: rtl/rs_issue_scheduler.sv
// Reservation-station issue scheduler: per-FU oldest-ready pick into a
// valid/ready hold slot, with FU3 (memory) non-pipelined occupancy tracking.
module rs_issue_scheduler #(
  parameter int RS_ROWS     = 16,
  parameter int IDX_W       = 4,
  parameter int MEM_LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic [3:0]           rob_head,
  input  logic [RS_ROWS-1:0]   row_in_use,
  input  logic [RS_ROWS-1:0]   row_src0_ready,
  input  logic [RS_ROWS-1:0]   row_src1_ready,
  input  logic [2*RS_ROWS-1:0] row_fu,
  input  logic [4*RS_ROWS-1:0] row_rob,
  input  logic [2:0]           fu_ready,
  output logic [2:0]           iss_valid,
  output logic [IDX_W-1:0]     iss_idx0,
  output logic [IDX_W-1:0]     iss_idx1,
  output logic [IDX_W-1:0]     iss_idx2,
  output logic [RS_ROWS-1:0]   row_issued,
  output logic                 fu3_busy
);
  localparam int unsigned NUM_FU = 3;
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic {IDLE, HOLD} slot_state_e;

  slot_state_e      state_q  [NUM_FU];
  slot_state_e      state_d  [NUM_FU];
  logic [IDX_W-1:0] idx_q    [NUM_FU];
  logic [IDX_W-1:0] idx_d    [NUM_FU];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_FU-1:0]  holding, dropped, accepted, found;
  logic [RS_ROWS-1:0] held_rows, accepted_rows;
  logic [IDX_W-1:0]   pick     [NUM_FU];
  logic [3:0]         best_age [NUM_FU];
  logic               fu3_may_load;

  always_comb begin
    holding       = '0;
    dropped       = '0;
    accepted      = '0;
    held_rows     = '0;
    accepted_rows = '0;
    for (int unsigned n = 0; n < NUM_FU; n++) begin
      holding[n]  = (state_q[n] == HOLD);
      // A held row whose in_use fell is abandoned; fu_ready is ignored for it
      dropped[n]  = holding[n] && !row_in_use[idx_q[n]];
      accepted[n] = reset_n && !flush && holding[n] && !dropped[n] && fu_ready[n];
      if (holding[n])  held_rows[idx_q[n]]     = 1'b1;
      if (accepted[n]) accepted_rows[idx_q[n]] = 1'b1;
    end
  end

  always_comb begin
    logic [3:0] age;
    logic       base;
    age   = '0;
    base  = 1'b0;
    found = '0;
    for (int unsigned n = 0; n < NUM_FU; n++) begin
      pick[n]     = '0;
      best_age[n] = '1;
    end
    // Ascending scan with strict compare gives lowest index on equal age
    for (int unsigned i = 0; i < RS_ROWS; i++) begin
      age  = row_rob[4*i +: 4] - rob_head;
      base = row_in_use[i] && row_src0_ready[i] && row_src1_ready[i] &&
             !held_rows[i] && !accepted_rows[i];
      for (int unsigned n = 0; n < NUM_FU; n++) begin
        if (base && (row_fu[2*i +: 2] == 2'(n)) && (!found[n] || (age < best_age[n]))) begin
          found[n]    = 1'b1;
          pick[n]     = IDX_W'(i);
          best_age[n] = age;
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (flush)
      cnt_d = '0;
    else if (accepted[2])
      cnt_d = CNT_W'(MEM_LATENCY - 1);
    else if (cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
    // FU3 reloads only when the counter is idle now and stays idle
    fu3_may_load = (cnt_q == '0) && (cnt_d == '0);

    for (int unsigned n = 0; n < NUM_FU; n++) begin
      state_d[n] = state_q[n];
      idx_d[n]   = idx_q[n];
      if (flush || dropped[n]) begin
        state_d[n] = IDLE;
      end else if (!holding[n] || accepted[n]) begin
        if (found[n] && ((n != 2) || fu3_may_load)) begin
          state_d[n] = HOLD;
          idx_d[n]   = pick[n];
        end else begin
          state_d[n] = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned n = 0; n < NUM_FU; n++) begin
        state_q[n] <= IDLE;
        idx_q[n]   <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int unsigned n = 0; n < NUM_FU; n++) begin
        state_q[n] <= state_d[n];
        idx_q[n]   <= idx_d[n];
      end
      cnt_q <= cnt_d;
    end
  end

  assign iss_valid  = holding;
  assign iss_idx0   = idx_q[0];
  assign iss_idx1   = idx_q[1];
  assign iss_idx2   = idx_q[2];
  assign row_issued = accepted_rows;
  assign fu3_busy   = (cnt_q != '0);

endmodule

// File: doc/rs_issue_scheduler.md
Name: rs_issue_scheduler

Overview:
Selects ready reservation-station rows and issues them to the three functional units: FU1 (fu=00), FU2 (fu=01) and FU3 (fu=10, memory only).
- Per FU, picks the oldest ready row by ROB age relative to the ROB head.
- Holds the pick with a valid/ready handshake until the FU accepts it.
- Pulses a per-row free signal back to the RS on acceptance.
- Enforces FU3's non-pipelined occupancy.
- Sits between the RS array and the FU/complete stage.

Parameters:
RS_ROWS, 16, number of RS rows scanned.
IDX_W, 4, row-index width; must equal clog2(RS_ROWS).
MEM_LATENCY, 3, cycles FU3 is occupied per accepted op; must be >= 1.

Ports:
clk  in  1  clock.
reset_n  in  1  synchronous, active-low reset.
flush  in  1  synchronous pipeline flush.
rob_head  in  4  ROB number of the oldest in-flight instruction.
row_in_use  in  RS_ROWS  rs_row in_use per row.
row_src0_ready  in  RS_ROWS  Src0Ready per row.
row_src1_ready  in  RS_ROWS  Src1Ready per row.
row_fu  in  2*RS_ROWS  fu field; row i at [2i+1:2i].
row_rob  in  4*RS_ROWS  ROBNumber; row i at [4i+3:4i].
fu_ready  in  3  FU n can accept this cycle.
iss_valid  out  3  FU n has a held issue.
iss_idx0  out  IDX_W  row index held for FU1.
iss_idx1  out  IDX_W  row index held for FU2.
iss_idx2  out  IDX_W  row index held for FU3.
row_issued  out  RS_ROWS  one-cycle pulse per accepted row; the RS clears in_use on it.
fu3_busy  out  1  FU3 occupancy counter nonzero.

Behaviour:
- Clock: single clock clk. Reset: synchronous and active-low on reset_n.
- Reset (reset_n=0 at a clk edge): iss_valid=0, all iss_idx=0, row_issued=0, FU3 counter=0, fu3_busy=0. Reset has priority over flush.
- Eligibility: a row is eligible for FU n when all of the following hold:
  - in_use, src0_ready and src1_ready are all high;
  - its fu field equals n;
  - it is not currently held by any FU slot;
  - it is not being accepted this cycle.
  - fu=11 is never eligible.
- Age: age = (row_rob - rob_head) mod 16, computed in 4-bit arithmetic so it wraps. The smallest age wins; ties go to the lowest row index.
- Per-FU slot FSM, states IDLE and HOLD:
  - IDLE: if any row is eligible (and, for FU3, the counter is 0), latch its index and go to HOLD. iss_valid rises the next cycle.
  - HOLD: iss_valid=1 and iss_idx stays stable until acceptance.
  - Acceptance occurs when iss_valid & fu_ready. In that cycle, row_issued[idx]=1 combinationally.
  - After acceptance, if another eligible row exists (excluding the accepted row), the slot reloads and stays in HOLD; back-to-back issue every cycle is allowed. Otherwise the slot goes to IDLE.
- Latency: a row that becomes eligible in cycle N shows iss_valid no earlier than N+1. Issue is never combinational from the row inputs.
- FU3 occupancy:
  - On FU3 acceptance, the counter loads MEM_LATENCY-1 and decrements to 0; fu3_busy = (counter != 0).
  - While busy, the FU3 slot does not load.
  - With MEM_LATENCY=1 there is no stall.
- Dropped hold: if the held row's in_use is low, the slot returns to IDLE next cycle with no row_issued pulse. Same-cycle fu_ready is ignored.
- Flush (flush=1, reset_n=1): all slots go to IDLE, iss_valid=0 next cycle, FU3 counter=0. row_issued is forced to 0 that cycle even if fu_ready is high. Nothing loads that cycle.
- The FU1, FU2 and FU3 slots operate independently. A row is held by at most one slot at a time, since fu is unique per row.
- row_issued may have up to 3 bits set in one cycle (one per FU).

Test Plan:
1. Reset: hold reset_n=0 for 2 cycles with all rows ready -> iss_valid=000 and row_issued=0 throughout; first iss_valid appears 1 cycle after reset_n=1.
2. Age with wrap: rob_head=14; FU1-ready rows 2 (rob 1), 5 (rob 15), 9 (rob 14) -> iss_idx0=9, then 5, then 2 on consecutive cycles with fu_ready[0]=1; row_issued pulses 1<<9, 1<<5, 1<<2.
3. Backpressure: row 3 on FU2, fu_ready[1]=0 for 4 cycles -> iss_valid[1]=1 and iss_idx1=3 stable with no pulse; fu_ready[1]=1 -> row_issued[3]=1 for exactly 1 cycle.
4. FU3 occupancy: MEM_LATENCY=3, rows 0 and 1 on fu=10, fu_ready[2]=1 -> row 0 accepted at cycle T; fu3_busy=1 for 2 cycles; row 1 accepted no earlier than T+3.
5. Flush: all three FUs holding with fu_ready=111 and flush=1 in the same cycle -> row_issued=0 that cycle, iss_valid=000 next cycle, fu3_busy=0.
6. Dropped hold: FU1 holding row 7 and row_in_use[7] drops -> iss_valid[0]=0 next cycle; row_issued[7] never pulses.
